// File: rtl/sd_router_pkg.sv
// Shared types and end-of-chain thresholds for the SD sector router.
package sd_router_pkg;

   typedef enum logic [1:0] {
      MODE_DIR  = 2'd0,
      MODE_FAT  = 2'd1,
      MODE_DATA = 2'd2,
      MODE_RSVD = 2'd3
   } rd_mode_t;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_ISSUE,
      ST_STREAM,
      ST_FINISH
   } rd_state_t;

   localparam logic [15:0] EOC_THR_16 = 16'hFFF8;
   localparam logic [23:0] EOC_THR_24 = 24'hFFFFF8;
   localparam logic [27:0] EOC_THR_32 = 28'hFFFFFF8;

   // FAT32 ignores the top nibble; narrower formats compare their full width.
   function automatic logic eoc_hit(input logic [31:0] entry, input int entry_bytes);
      case (entry_bytes)
         2:       return (entry & 32'h0000_FFFF) >= 32'(EOC_THR_16);
         3:       return (entry & 32'h00FF_FFFF) >= 32'(EOC_THR_24);
         default: return (entry & 32'h0FFF_FFFF) >= 32'(EOC_THR_32);
      endcase
   endfunction

endpackage

// File: rtl/sd_sector_router_if.sv
// Request, SD byte stream and routed-output bundle between FAT walker, sd_controller and the router.
interface sd_sector_router_if #(
   parameter int BLOCK_BYTES = 512,
   parameter int ENTRY_BYTES = 4
);
   localparam int OFS_W = $clog2(BLOCK_BYTES);

   logic                     req_valid;
   logic                     req_ready;
   logic [1:0]               req_mode;
   logic [31:0]              req_lba;
   logic [OFS_W-1:0]         req_offset;
   logic                     sd_rd;
   logic [31:0]              sd_addr;
   logic [7:0]               sd_byte;
   logic                     sd_byte_vld;
   logic                     sd_done;
   logic                     bram_we;
   logic [OFS_W-1:0]         bram_addr;
   logic [7:0]               bram_wdata;
   logic [7:0]               fifo_data;
   logic                     fifo_valid;
   logic                     fifo_full;
   logic                     fifo_ovf;
   logic [8*ENTRY_BYTES-1:0] entry_data;
   logic                     entry_valid;
   logic                     entry_part;
   logic                     entry_eoc;
   logic                     blk_done;
   logic                     short_err;

   modport slave (
      input  req_valid, req_mode, req_lba, req_offset,
      input  sd_byte, sd_byte_vld, sd_done, fifo_full,
      output req_ready, sd_rd, sd_addr,
      output bram_we, bram_addr, bram_wdata,
      output fifo_data, fifo_valid, fifo_ovf,
      output entry_data, entry_valid, entry_part, entry_eoc,
      output blk_done, short_err
   );

   modport master (
      output req_valid, req_mode, req_lba, req_offset,
      output sd_byte, sd_byte_vld, sd_done, fifo_full,
      input  req_ready, sd_rd, sd_addr,
      input  bram_we, bram_addr, bram_wdata,
      input  fifo_data, fifo_valid, fifo_ovf,
      input  entry_data, entry_valid, entry_part, entry_eoc,
      input  blk_done, short_err
   );

endinterface

// File: rtl/sd_sector_router_entry_assembler.sv
// FAT entry lane capture with cross-sector continuation; optional EOC flag under SD_ROUTER_EOC_DETECT_EN.
module sd_entry_assembler
   import sd_router_pkg::*;
#(
   parameter int BLOCK_BYTES = 512,
   parameter int ENTRY_BYTES = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     start_i,
   input  logic                     fat_i,
   input  logic [$clog2(BLOCK_BYTES)-1:0] offset_i,
   input  logic                     stb_i,
   input  logic [$clog2(BLOCK_BYTES):0]   idx_i,
   input  logic [7:0]               byte_i,
   input  logic                     fin_i,
   input  logic                     short_i,
   output logic [8*ENTRY_BYTES-1:0] entry_data_o,
   output logic                     entry_valid_o,
   output logic                     entry_part_o,
   output logic                     entry_eoc_o
);
   localparam int OFS_W = $clog2(BLOCK_BYTES);
   localparam int EW    = 8 * ENTRY_BYTES;
   localparam logic [2:0] NLANE = 3'(ENTRY_BYTES);

   logic [2:0]     pend_q;
   logic [OFS_W:0] lo_q;
   logic [2:0]     need_q;
   logic [2:0]     lane0_q;
   logic [2:0]     got_q;
   logic           act_q;
   logic           cmpl_q;
   logic [EW-1:0]  lanes_q;
   logic [EW-1:0]  out_q;
   logic           valid_q;

   logic [OFS_W:0] rel;
   logic [2:0]     lane;
   logic           hit;
   logic           last;
   logic           part;
   logic [EW-1:0]  asm;

   // Window [lo, lo+need) maps onto lanes starting at lane0; a continuation starts mid-entry.
   assign rel  = idx_i - lo_q;
   assign hit  = stb_i && act_q && !cmpl_q && (idx_i >= lo_q) && (rel < (OFS_W+1)'(need_q));
   assign lane = lane0_q + rel[2:0];
   assign last = hit && (lane == NLANE - 3'd1);
   assign part = fin_i && act_q && !cmpl_q && !short_i;

   generate
      for (genvar gi = 0; gi < ENTRY_BYTES; gi++) begin : g_lane
         assign asm[8*gi +: 8] = (hit && lane == 3'(gi)) ? byte_i : lanes_q[8*gi +: 8];
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (rst) begin
         pend_q  <= '0;
         lo_q    <= '0;
         need_q  <= '0;
         lane0_q <= '0;
         got_q   <= '0;
         act_q   <= 1'b0;
         cmpl_q  <= 1'b0;
         lanes_q <= '0;
         out_q   <= '0;
         valid_q <= 1'b0;
      end else begin
         valid_q <= last;
         if (hit) begin
            lanes_q <= asm;
            got_q   <= got_q + 3'd1;
         end
         if (last) begin
            cmpl_q <= 1'b1;
            out_q  <= asm;
         end
         if (start_i) begin
            act_q  <= fat_i;
            cmpl_q <= 1'b0;
            got_q  <= '0;
            pend_q <= '0;
            if (fat_i && pend_q != 3'd0) begin
               lo_q    <= '0;
               lane0_q <= NLANE - pend_q;
               need_q  <= pend_q;
            end else begin
               lo_q    <= {1'b0, offset_i};
               lane0_q <= '0;
               need_q  <= NLANE;
            end
         end else if (fin_i) begin
            act_q  <= 1'b0;
            pend_q <= part ? (NLANE - lane0_q - got_q) : 3'd0;
         end
      end
   end

   assign entry_data_o  = out_q;
   assign entry_valid_o = valid_q;
   assign entry_part_o  = part;

`ifdef SD_ROUTER_EOC_DETECT_EN
   logic eoc_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         eoc_q <= 1'b0;
      end else if (last) begin
         eoc_q <= eoc_hit(32'(asm), ENTRY_BYTES);
      end
   end

   assign entry_eoc_o = valid_q && eoc_q;
`else
   assign entry_eoc_o = 1'b0;
`endif

endmodule

// File: rtl/sd_sector_router.sv
// One-sector SD read issuer routing bytes to directory BRAM, FAT entry assembler or audio FIFO.
// Optional end-of-chain detection is enabled by defining SD_ROUTER_EOC_DETECT_EN.
module sd_sector_router
   import sd_router_pkg::*;
#(
   parameter int BLOCK_BYTES = 512,
   parameter int ENTRY_BYTES = 4
) (
   input  logic               clk,
   input  logic               rst,
   sd_sector_router_if.slave  bus
);
   localparam int OFS_W = $clog2(BLOCK_BYTES);
   localparam logic [OFS_W:0] BLK_CNT = (OFS_W+1)'(BLOCK_BYTES);

   rd_state_t      state_q, state_d;
   rd_mode_t       mode_q;
   logic [31:0]    lba_q;
   logic [OFS_W:0] cnt_q;
   logic           done_q;
   logic           ovf_q;

   logic accept;
   logic done_rise;
   logic byte_stb;
   logic fin;

   assign accept    = bus.req_valid && (state_q == ST_IDLE);
   assign done_rise = bus.sd_done && !done_q;
   // Bytes past a full sector are dropped so the BRAM index never wraps.
   assign byte_stb  = (state_q == ST_STREAM) && bus.sd_byte_vld && (cnt_q < BLK_CNT);
   assign fin       = (state_q == ST_FINISH);

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:   if (accept) state_d = ST_ISSUE;
         ST_ISSUE:  state_d = ST_STREAM;
         ST_STREAM: if (done_rise) state_d = ST_FINISH;
         ST_FINISH: state_d = ST_IDLE;
         default:   state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         mode_q <= MODE_DIR;
         lba_q  <= '0;
         cnt_q  <= '0;
         done_q <= 1'b0;
         ovf_q  <= 1'b0;
      end else begin
         done_q <= bus.sd_done;
         if (accept) begin
            mode_q <= rd_mode_t'(bus.req_mode);
            lba_q  <= bus.req_lba;
            cnt_q  <= '0;
         end else if (byte_stb) begin
            cnt_q <= cnt_q + 1'b1;
         end
         if (byte_stb && mode_q == MODE_DATA && bus.fifo_full) begin
            ovf_q <= 1'b1;
         end
      end
   end

   assign bus.req_ready  = (state_q == ST_IDLE);
   assign bus.sd_rd      = (state_q == ST_ISSUE);
   assign bus.sd_addr    = lba_q;
   assign bus.bram_we    = byte_stb && (mode_q == MODE_DIR);
   assign bus.bram_addr  = cnt_q[OFS_W-1:0];
   assign bus.bram_wdata = bus.bram_we ? bus.sd_byte : 8'h00;
   assign bus.fifo_valid = byte_stb && (mode_q == MODE_DATA) && !bus.fifo_full;
   assign bus.fifo_data  = bus.fifo_valid ? bus.sd_byte : 8'h00;
   assign bus.fifo_ovf   = ovf_q;
   assign bus.blk_done   = fin;
   assign bus.short_err  = fin && (cnt_q < BLK_CNT);

   sd_entry_assembler #(
      .BLOCK_BYTES (BLOCK_BYTES),
      .ENTRY_BYTES (ENTRY_BYTES)
   ) u_entry (
      .clk           (clk),
      .rst           (rst),
      .start_i       (accept),
      .fat_i         (bus.req_mode == 2'(MODE_FAT)),
      .offset_i      (bus.req_offset),
      .stb_i         (byte_stb && (mode_q == MODE_FAT)),
      .idx_i         (cnt_q),
      .byte_i        (bus.sd_byte),
      .fin_i         (fin),
      .short_i       (cnt_q < BLK_CNT),
      .entry_data_o  (bus.entry_data),
      .entry_valid_o (bus.entry_valid),
      .entry_part_o  (bus.entry_part),
      .entry_eoc_o   (bus.entry_eoc)
   );

endmodule
